// File: rtl/approx_seg_mul_if.sv
// Operand/result handshake bundle for approx_seg_mul. The master drives operands and
// out_ready; the slave (the multiplier) drives in_ready and the result.
interface approx_seg_mul_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [SW-1:0]        out_shift_a;
  logic [SW-1:0]        out_shift_b;

  modport master (
    output in_valid, in_a, in_b, mode, out_ready,
    input  in_ready, out_valid, out_p, out_shift_a, out_shift_b
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, out_ready,
    output in_ready, out_valid, out_p, out_shift_a, out_shift_b
  );
endinterface

// File: rtl/approx_seg_mul.sv
// Three-stage segmented (approximate/exact) unsigned multiplier: leading-one detect,
// segment multiply, re-align shift. Define APPROX_SEG_MUL_ROUND_EN to force the LSB of truncated segments.
module approx_seg_mul #(
  parameter int WIDTH = 16,
  parameter int KEEP  = 8
) (
  input  logic             clk,
  input  logic             reset,
  approx_seg_mul_if.slave  bus
);
  localparam int SW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [SW-1:0] KEEP_W = SW'(KEEP);

  typedef struct packed {
    logic [SW-1:0]    shift;
    logic [WIDTH-1:0] seg;
  } seg_t;

  // 1-based position of the most significant one; 0 for a zero operand.
  function automatic logic [SW-1:0] lead_one(input logic [WIDTH-1:0] x);
    logic [SW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) p = SW'(i + 1);
    end
    return p;
  endfunction

  function automatic seg_t segment(input logic [WIDTH-1:0] x, input logic approx);
    seg_t          r;
    logic [SW-1:0] p;
    p       = lead_one(x);
    r.shift = (approx && (p > KEEP_W)) ? p - KEEP_W : '0;
    r.seg   = x >> r.shift;
`ifdef APPROX_SEG_MUL_ROUND_EN
    if (r.shift != '0) r.seg[0] = 1'b1;
`endif
    return r;
  endfunction

  logic             en;
  logic             s1_valid_q, s1_valid_d;
  seg_t             s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_m_q, s2_m_d;
  logic [SW-1:0]    s2_sa_q, s2_sa_d, s2_sb_q, s2_sb_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic [SW-1:0]    out_sa_q, out_sa_d, out_sb_q, out_sb_d;
  logic [SW:0]      tot_shift;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_m_d      = s2_m_q;
    s2_sa_d     = s2_sa_q;
    s2_sb_d     = s2_sb_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_sa_d    = out_sa_q;
    out_sb_d    = out_sb_q;
    tot_shift   = {1'b0, s2_sa_q} + {1'b0, s2_sb_q};
    en          = !out_valid_q || bus.out_ready;

    // A single advance strobe moves the whole pipe, so a stalled output freezes every stage.
    if (en) begin
      s1_valid_d  = bus.in_valid;
      s1_a_d      = segment(bus.in_a, bus.mode);
      s1_b_d      = segment(bus.in_b, bus.mode);
      s2_valid_d  = s1_valid_q;
      s2_m_d      = PW'(s1_a_q.seg) * PW'(s1_b_q.seg);
      s2_sa_d     = s1_a_q.shift;
      s2_sb_d     = s1_b_q.shift;
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_p_d  = s2_m_q << tot_shift;
        out_sa_d = s2_sa_q;
        out_sb_d = s2_sb_q;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_sa_q    <= '0;
      out_sb_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_sa_q    <= out_sa_d;
      out_sb_q    <= out_sb_d;
    end
  end

  // NOTE: internal datapath flops carry no reset; their per-stage valid bit qualifies them.
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s2_m_q  <= s2_m_d;
    s2_sa_q <= s2_sa_d;
    s2_sb_q <= s2_sb_d;
  end

  assign bus.in_ready    = en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_p       = out_p_q;
  assign bus.out_shift_a = out_sa_q;
  assign bus.out_shift_b = out_sb_q;
endmodule

// File: doc/approx_seg_mul.md
APPROX_SEG_MUL -- requirements
Module: approx_seg_mul

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand width in bits (legal range 4..32).
REQ-002 SHALL have parameter KEEP, 8, retained segment width in approximate mode (legal range 2..WIDTH).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port in_b  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port mode  input  1  0 = exact, 1 = approximate; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_p  output  2*WIDTH  product.
REQ-013 SHALL have port out_shift_a  output  clog2(WIDTH)+1  bits dropped from A.
REQ-014 SHALL have port out_shift_b  output  clog2(WIDTH)+1  bits dropped from B.

Function
REQ-015 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-016 SHALL be 3 stages: S1 leading-one detect, S2 segment multiply, S3 re-align shift; one per-stage valid bit.
REQ-017 SHALL use global advance en = !out_valid || out_ready; in_ready = en; all stages hold when en = 0.
REQ-018 SHALL present a result 3 cycles after acceptance with no stall; throughput one per cycle.
REQ-019 S1 SHALL compute p = 1-based index of most significant 1 (p = 0 for zero operand), per operand, with full priority over all WIDTH bits.
REQ-020 Approximate mode: shift = (p > KEEP) ? p - KEEP : 0; seg = x >> shift (at most KEEP significant bits).
REQ-021 Exact mode: shift = 0, seg = x.
REQ-022 S2 SHALL form m = seg_a * seg_b at full 2*WIDTH width, no truncation of m.
REQ-023 S3 SHALL form out_p = m << (shift_a + shift_b); result never exceeds 2*WIDTH bits, no overflow.
REQ-024 out_shift_a/out_shift_b SHALL carry the shifts of the same transaction as out_p.
REQ-025 out_p, out_shift_* SHALL stay stable while out_valid && !out_ready.
REQ-026 Zero operand SHALL give out_p = 0 in both modes.
REQ-027 mode SHALL travel with its transaction; per-cycle mode changes are legal.

Reset
REQ-028 On reset all stage valids, out_valid SHALL clear at the next clock edge, including mid-pipeline; in-flight transactions are discarded.
REQ-029 out_p, out_shift_a, out_shift_b SHALL reset to 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro APPROX_SEG_MUL_ROUND_EN defined: when shift > 0, seg = (x >> shift) | 1 (bias compensation); shift = 0 unaffected.
REQ-032 Macro undefined: plain truncation per REQ-020; no compensation logic present.

Verification (WIDTH=16, KEEP=8)
REQ-033 a=0xFFFF, b=0xFFFF, mode=1 -> out_p=0xFE010000, shifts 8/8; mode=0 -> 0xFFFE0001, shifts 0/0.
REQ-034 a=0x1234, b=0x0100, mode=1 -> out_p=0x00122000, shifts 5/1 (ROUND_EN: 0x00124440); mode=0 -> 0x00123400.
REQ-035 a=0x00FF, b=0x0003, mode=1 -> out_p=0x000002FD, shifts 0/0; a=0, b=0xFFFF -> out_p=0.
REQ-036 4 back-to-back transactions, out_ready=0 from cycle 3 for 5 cycles -> in_ready=0 once full, out_p held, all 4 delivered in order, none lost or duplicated.
REQ-037 reset asserted 1 cycle with 2 transactions in flight -> out_valid=0, out_p=0 next cycle; no stale result appears afterwards.
